// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage IEEE-style floating-point compare / min / max with ready-valid flow control.
// S1 holds operands plus NaN/zero classification; S2 holds the ordered result and selected value.
module fp_compare_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int CNT_W = 16,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     X,
    input  logic [W-1:0]     Y,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       result,
    output logic             unordered,
    output logic [W-1:0]     sel_out,
    output logic [CNT_W-1:0] nan_count
);
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic         s1_valid;
    logic [W-1:0] s1_x, s1_y;
    logic [1:0]   s1_mode;
    logic         s1_xn, s1_yn, s1_xz, s1_yz;
    logic         s2_adv, s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Classification of the incoming operands, registered into S1
    logic x_nan, y_nan, x_zero, y_zero;
    assign x_nan  = (&X[W-2:MAN_W]) && (|X[MAN_W-1:0]);
    assign y_nan  = (&Y[W-2:MAN_W]) && (|Y[MAN_W-1:0]);
    assign x_zero = ~|X[W-2:0];
    assign y_zero = ~|Y[W-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= 2'b00;
            s1_xn    <= 1'b0;
            s1_yn    <= 1'b0;
            s1_xz    <= 1'b0;
            s1_yz    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x    <= X;
                s1_y    <= Y;
                s1_mode <= mode;
                s1_xn   <= x_nan;
                s1_yn   <= y_nan;
                s1_xz   <= x_zero;
                s1_yz   <= y_zero;
            end
        end
    end

    logic         sx, sy, any_nan, both_zero, mag_gt, ord_gt, eq, gt, lt, is_min, is_max;
    logic [2:0]   res_c;
    logic [W-1:0] sel_c;

    // Signs decide differing-sign pairs; for two negatives the magnitude sense flips
    always_comb begin
        sx        = s1_x[W-1];
        sy        = s1_y[W-1];
        any_nan   = s1_xn || s1_yn;
        both_zero = s1_xz && s1_yz;
        mag_gt    = s1_x[W-2:0] > s1_y[W-2:0];
        eq        = !any_nan && (both_zero || s1_x == s1_y);
        ord_gt    = (sx != sy) ? !sx : (sx ? !mag_gt : mag_gt);
        gt        = !any_nan && !eq && ord_gt;
        lt        = !any_nan && !eq && !ord_gt;
        res_c     = {gt, lt, eq};
        is_min    = s1_mode == 2'b01;
        is_max    = s1_mode == 2'b10;
        sel_c     = !(is_min || is_max) ? s1_x :
                    (s1_xn && s1_yn)    ? CANON_NAN :
                    s1_xn               ? s1_y :
                    s1_yn               ? s1_x :
                    both_zero           ? {(is_min ? (sx | sy) : (sx & sy)), {(W-1){1'b0}}} :
                    eq                  ? s1_x :
                    (gt == is_max)      ? s1_x : s1_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= 3'b000;
            unordered <= 1'b0;
            sel_out   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result    <= res_c;
                unordered <= any_nan;
                sel_out   <= sel_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            nan_count <= '0;
        else if (out_valid && out_ready && unordered && nan_count != {CNT_W{1'b1}})
            nan_count <= nan_count + CNT_W'(1);
    end
endmodule
